// File: rtl/modulo_salva_contexto_if.sv
// Purpose: groups the core-facing signals of modulo_salva_contexto.
//   master : core side (drives PC, base, decoded requests and the REG_RETORNO value)
//   slave  : context-save block (drives stall, redirect and the register-file override port)
// Signals:
//   pc_atual, reg_base, req_syscall, req_retorno, valor_retorno  core -> block
//   stall, desvio_valido, endereco_desvio, rf_we, rf_addr,
//   rf_data, modo_user                                          block -> core
interface modulo_salva_contexto_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5
);
  logic [ADDR_WIDTH-1:0] pc_atual;
  logic [DATA_WIDTH-1:0] reg_base;
  logic                  req_syscall;
  logic                  req_retorno;
  logic [DATA_WIDTH-1:0] valor_retorno;
  logic                  stall;
  logic                  desvio_valido;
  logic [ADDR_WIDTH-1:0] endereco_desvio;
  logic                  rf_we;
  logic [REG_WIDTH-1:0]  rf_addr;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  modo_user;

  modport master (
    output pc_atual, reg_base, req_syscall, req_retorno, valor_retorno,
    input  stall, desvio_valido, endereco_desvio, rf_we, rf_addr, rf_data, modo_user
  );

  modport slave (
    input  pc_atual, reg_base, req_syscall, req_retorno, valor_retorno,
    output stall, desvio_valido, endereco_desvio, rf_we, rf_addr, rf_data, modo_user
  );
endinterface

// File: rtl/modulo_salva_contexto.sv
// Purpose: saves/restores the user-program context around SYSCALL and return-to-user.
//   SYSCALL from user mode : writes the program-relative return PC (PC+1-base) into
//                            REG_RETORNO, then redirects the PC to the SO vector.
//   Return from the SO     : rebuilds the absolute target (relative value + base) and
//                            redirects the PC into the user program.
//   The core is stalled while the sequence runs.
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  asynchronous active-high reset
//   bus    slave modport of modulo_salva_contexto_if (requests in; stall, redirect,
//          register-file write and mode flag out)
module modulo_salva_contexto #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 32,
  parameter int REG_WIDTH   = 5,
  parameter int LIMITE_USER = 1000,
  parameter int VETOR_SO    = 0,
  parameter int REG_RETORNO = 26
) (
  input  logic                    clock,
  input  logic                    reset,
  modulo_salva_contexto_if.slave  bus
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    SALVA     = 2'd1,
    DESVIO_SO = 2'd2,
    RESTAURA  = 2'd3
  } estado_t;

  estado_t               r_estado;
  estado_t               w_estado_next;
  logic [ADDR_WIDTH-1:0] r_ret_rel;
  logic [ADDR_WIDTH-1:0] w_ret_rel_next;
  logic [ADDR_WIDTH-1:0] r_alvo;
  logic [ADDR_WIDTH-1:0] w_alvo_next;

  logic                  r_stall;
  logic                  r_desvio_valido;
  logic [ADDR_WIDTH-1:0] r_endereco_desvio;
  logic                  r_rf_we;
  logic [REG_WIDTH-1:0]  r_rf_addr;
  logic [DATA_WIDTH-1:0] r_rf_data;
  logic                  r_modo_user;

  logic                  w_stall_next;
  logic                  w_desvio_valido_next;
  logic [ADDR_WIDTH-1:0] w_endereco_desvio_next;
  logic                  w_rf_we_next;
  logic [REG_WIDTH-1:0]  w_rf_addr_next;
  logic [DATA_WIDTH-1:0] w_rf_data_next;
  logic                  w_modo_user_next;

  logic                  w_modo_pc_user;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_pc_mais_um;
  logic                  w_unused_bits;

  // Only the low address bits of the base and of the relative value matter.
  assign w_base         = bus.reg_base[ADDR_WIDTH-1:0];
  assign w_modo_pc_user = (bus.pc_atual >= ADDR_WIDTH'(LIMITE_USER));
  // The +1 wraps before the base is subtracted, so PC=2^N-1 returns to relative 0-base.
  assign w_pc_mais_um   = bus.pc_atual + ADDR_WIDTH'(1);
  assign w_unused_bits  = ^{bus.reg_base[DATA_WIDTH-1:ADDR_WIDTH],
                            bus.valor_retorno[DATA_WIDTH-1:ADDR_WIDTH]};

  // Next state and latched addresses.
  always_comb begin
    w_estado_next  = r_estado;
    w_ret_rel_next = r_ret_rel;
    w_alvo_next    = r_alvo;
    case (r_estado)
      OCIOSO: begin
        if (bus.req_syscall && w_modo_pc_user) begin
          w_ret_rel_next = w_pc_mais_um - w_base;
          w_estado_next  = SALVA;
        end else if (bus.req_retorno && !w_modo_pc_user) begin
          w_alvo_next   = bus.valor_retorno[ADDR_WIDTH-1:0] + w_base;
          w_estado_next = RESTAURA;
        end
      end
      SALVA:     w_estado_next = DESVIO_SO;
      DESVIO_SO: w_estado_next = OCIOSO;
      RESTAURA:  w_estado_next = OCIOSO;
      default:   w_estado_next = OCIOSO;
    endcase
  end

  // Outputs are decoded from the next state so that the output registers
  // always reflect the state being entered (Moore, but without a decode delay).
  always_comb begin
    w_stall_next           = (w_estado_next != OCIOSO);
    w_rf_we_next           = 1'b0;
    w_rf_addr_next         = '0;
    w_rf_data_next         = '0;
    w_desvio_valido_next   = 1'b0;
    w_endereco_desvio_next = '0;
    w_modo_user_next       = r_modo_user;
    case (w_estado_next)
      SALVA: begin
        w_rf_we_next   = 1'b1;
        w_rf_addr_next = REG_WIDTH'(REG_RETORNO);
        w_rf_data_next = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_ret_rel_next};
      end
      DESVIO_SO: begin
        w_desvio_valido_next   = 1'b1;
        w_endereco_desvio_next = ADDR_WIDTH'(VETOR_SO);
        w_modo_user_next       = 1'b0;
      end
      RESTAURA: begin
        w_desvio_valido_next   = 1'b1;
        w_endereco_desvio_next = w_alvo_next;
        w_modo_user_next       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado          <= OCIOSO;
      r_ret_rel         <= '0;
      r_alvo            <= '0;
      r_stall           <= 1'b0;
      r_desvio_valido   <= 1'b0;
      r_endereco_desvio <= '0;
      r_rf_we           <= 1'b0;
      r_rf_addr         <= '0;
      r_rf_data         <= '0;
      r_modo_user       <= 1'b0;
    end else begin
      r_estado          <= w_estado_next;
      r_ret_rel         <= w_ret_rel_next;
      r_alvo            <= w_alvo_next;
      r_stall           <= w_stall_next;
      r_desvio_valido   <= w_desvio_valido_next;
      r_endereco_desvio <= w_endereco_desvio_next;
      r_rf_we           <= w_rf_we_next;
      r_rf_addr         <= w_rf_addr_next;
      r_rf_data         <= w_rf_data_next;
      r_modo_user       <= w_modo_user_next;
    end
  end

  assign bus.stall           = r_stall;
  assign bus.desvio_valido   = r_desvio_valido;
  assign bus.endereco_desvio = r_endereco_desvio;
  assign bus.rf_we           = r_rf_we;
  assign bus.rf_addr         = r_rf_addr;
  assign bus.rf_data         = r_rf_data;
  assign bus.modo_user       = r_modo_user;

endmodule

// File: tb/tb_modulo_salva_contexto.sv
module tb_modulo_salva_contexto;

  logic clock;
  logic reset;

  modulo_salva_contexto_if #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .REG_WIDTH(5)) bus ();

  modulo_salva_contexto dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int failures;
  int exp_modo;

  // kind: 0 = no activity expected, 1 = save sequence, 2 = restore sequence
  typedef struct {
    logic [12:0] pc;
    logic [31:0] base;
    logic        sys;
    logic        ret;
    logic [31:0] valor;
    int          kind;
    int          exp_val;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check_outs(input string tag, input int e_stall, input int e_we,
                            input int e_addr, input int e_data, input int e_desvio,
                            input int e_end, input int e_modo);
    check({tag, ".stall"},           int'(bus.stall),           e_stall);
    check({tag, ".rf_we"},           int'(bus.rf_we),           e_we);
    check({tag, ".rf_addr"},         int'(bus.rf_addr),         e_addr);
    check({tag, ".rf_data"},         int'(bus.rf_data),         e_data);
    check({tag, ".desvio_valido"},   int'(bus.desvio_valido),   e_desvio);
    check({tag, ".endereco_desvio"}, int'(bus.endereco_desvio), e_end);
    check({tag, ".modo_user"},       int'(bus.modo_user),       e_modo);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_modo = 0;

    vecs[0] = '{13'd1010, 32'd1000,       1'b1, 1'b0, 32'd0,    1, 11};
    vecs[1] = '{13'd999,  32'd1000,       1'b1, 1'b0, 32'd0,    0, 0};
    vecs[2] = '{13'd1000, 32'd1000,       1'b1, 1'b0, 32'd0,    1, 1};
    vecs[3] = '{13'd40,   32'd1000,       1'b0, 1'b1, 32'd11,   2, 1011};
    vecs[4] = '{13'd8191, 32'd1000,       1'b1, 1'b0, 32'd0,    1, 7192};
    vecs[5] = '{13'd40,   32'd1000,       1'b0, 1'b1, 32'd8000, 2, 808};
    vecs[6] = '{13'd1500, 32'd1000,       1'b0, 1'b1, 32'd5,    0, 0};
    vecs[7] = '{13'd5,    32'd2000,       1'b1, 1'b1, 32'd3,    2, 2003};
    vecs[8] = '{13'd2000, 32'hFFFF_03E8,  1'b1, 1'b0, 32'd0,    1, 1001};
    vecs[9] = '{13'd0,    32'd1000,       1'b1, 1'b0, 32'd0,    0, 0};

    bus.pc_atual      = '0;
    bus.reg_base      = '0;
    bus.req_syscall   = 1'b0;
    bus.req_retorno   = 1'b0;
    bus.valor_retorno = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(negedge clock);
      bus.pc_atual      = vecs[i].pc;
      bus.reg_base      = vecs[i].base;
      bus.req_syscall   = vecs[i].sys;
      bus.req_retorno   = vecs[i].ret;
      bus.valor_retorno = vecs[i].valor;
      @(posedge clock);
      #1;
      bus.req_syscall = 1'b0;
      bus.req_retorno = 1'b0;
      if (vecs[i].kind == 1) begin
        check_outs({tag, ".c1"}, 1, 1, 26, vecs[i].exp_val, 0, 0, exp_modo);
        exp_modo = 0;
        @(posedge clock); #1;
        check_outs({tag, ".c2"}, 1, 0, 0, 0, 1, 0, exp_modo);
        @(posedge clock); #1;
        check_outs({tag, ".c3"}, 0, 0, 0, 0, 0, 0, exp_modo);
        $display("vec%0d save pc=%0d base=%0d rf_data=%0d", i, vecs[i].pc, vecs[i].base[12:0], vecs[i].exp_val);
      end else if (vecs[i].kind == 2) begin
        exp_modo = 1;
        check_outs({tag, ".c1"}, 1, 0, 0, 0, 1, vecs[i].exp_val, exp_modo);
        @(posedge clock); #1;
        check_outs({tag, ".c2"}, 0, 0, 0, 0, 0, 0, exp_modo);
        $display("vec%0d restore pc=%0d valor=%0d endereco=%0d", i, vecs[i].pc, vecs[i].valor, vecs[i].exp_val);
      end else begin
        check_outs({tag, ".c1"}, 0, 0, 0, 0, 0, 0, exp_modo);
        @(posedge clock); #1;
        check_outs({tag, ".c2"}, 0, 0, 0, 0, 0, 0, exp_modo);
        $display("vec%0d ignored pc=%0d", i, vecs[i].pc);
      end
    end

    // Syscall held over SALVA and DESVIO_SO: only one sequence may run.
    begin
      int cnt_we;
      int cnt_desvio;
      cnt_we     = 0;
      cnt_desvio = 0;
      @(negedge clock);
      bus.pc_atual    = 13'd1010;
      bus.reg_base    = 32'd1000;
      bus.req_syscall = 1'b1;
      for (int c = 1; c <= 7; c++) begin
        @(posedge clock); #1;
        if (c == 2) bus.req_syscall = 1'b0;
        if (bus.rf_we) cnt_we++;
        if (bus.desvio_valido) cnt_desvio++;
      end
      check("held_syscall.rf_we_pulses", cnt_we, 1);
      check("held_syscall.desvio_pulses", cnt_desvio, 1);
      exp_modo = 0;
      $display("held syscall rf_we_pulses=%0d desvio_pulses=%0d", cnt_we, cnt_desvio);
    end

    // Enter user mode first so the reset also has to clear modo_user.
    @(negedge clock);
    bus.pc_atual      = 13'd40;
    bus.reg_base      = 32'd1000;
    bus.valor_retorno = 32'd20;
    bus.req_retorno   = 1'b1;
    @(posedge clock); #1;
    bus.req_retorno = 1'b0;
    check_outs("pre_reset", 1, 0, 0, 0, 1, 1020, 1);
    @(posedge clock); #1;

    // Reset in the middle of SALVA.
    @(negedge clock);
    bus.pc_atual    = 13'd1200;
    bus.req_syscall = 1'b1;
    @(posedge clock); #1;
    bus.req_syscall = 1'b0;
    check("mid_reset.rf_we_before", int'(bus.rf_we), 1);
    #1;
    reset = 1'b1;
    #1;
    check_outs("mid_reset.same_cycle", 0, 0, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b0;
    begin
      int cnt_act;
      cnt_act = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clock); #1;
        if (bus.desvio_valido || bus.rf_we || bus.stall) cnt_act++;
      end
      check("mid_reset.activity_after", cnt_act, 0);
      $display("reset during SALVA activity_after=%0d", cnt_act);
    end
    // FSM must be idle: a restore starts with single-cycle latency.
    @(negedge clock);
    bus.pc_atual      = 13'd40;
    bus.valor_retorno = 32'd7;
    bus.req_retorno   = 1'b1;
    @(posedge clock); #1;
    bus.req_retorno = 1'b0;
    check_outs("post_reset_restore", 1, 0, 0, 0, 1, 1007, 1);
    $display("post-reset restore endereco=%0d", bus.endereco_desvio);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
